if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the MIPS pipeline, directly upstream of the IF/ID register. It owns the program counter and drives a variable-latency instruction-ROM request/acknowledge handshake. It presents each fetched instruction with its PC to IF/ID and raises a stall request to the pipeline controller while a fetch is outstanding. It applies branch redirects (honouring the MIPS delay slot) and exception flush redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  reset_status_t  asynchronous, active-low; asserted when rst == RST_ENABLE (1'b0)
- stall  in  6  controller stall vector; stall[0] holds PC
- branch_flag_i  in  1  ID resolved a taken branch/jump this cycle
- branch_target_i  in  inst_addr_t  branch destination
- flush_i  in  1  exception/eret flush; higher priority than branch
- new_pc_i  in  inst_addr_t  flush destination
- rom_req  out  1  fetch request
- rom_addr  out  inst_addr_t  fetch address, stable while rom_req high and rom_ack low
- rom_ack  in  1  rom_data valid this cycle
- rom_data  in  inst_t  fetched word
- if_pc_o  out  inst_addr_t  PC of presented instruction
- rom_inst_o  out  inst_t  presented instruction (to IF/ID)
- stallreq_if_o  out  1  IF cannot supply an instruction this cycle
- if_adel_o  out  1  presented PC misaligned (see Configuration)

## Operation
- State register fetch_state_t: FETCH, HOLD, DRAIN. Registers: pc, inst_q, redir_pend, redir_tgt, dtgt.
- Reset: state=FETCH, pc=RESET_PC, inst_q=0, redir_pend=0, redir_tgt=0, dtgt=0. The first request issues in the first cycle after deassertion.
- FETCH: rom_req=1, rom_addr=pc.
  - On rom_ack with stall[0]=0: the instruction is consumed and pc takes the next PC; remain in FETCH.
  - On rom_ack with stall[0]=1: inst_q<=rom_data, go to HOLD.
- HOLD: rom_req=0. When stall[0]=0: pc takes the next PC, go to FETCH.
- Next PC: redir_tgt if redir_pend, else pc+4 (32-bit, wraps at 2^32). redir_pend clears when used.
- Branch: on branch_flag_i, set redir_pend=1 and redir_tgt=branch_target_i. The instruction currently in FETCH/HOLD (the delay slot) is still delivered.
- Flush: on flush_i, discard the current instruction and clear redir_pend.
  - In FETCH with rom_ack low: go to DRAIN with dtgt=new_pc_i.
  - Otherwise: pc=new_pc_i, go to FETCH.
- DRAIN: rom_req=1 at the old address; rom_data is discarded on ack. On ack: pc=dtgt, go to FETCH. A flush arriving in DRAIN overwrites dtgt. A branch arriving in DRAIN is ignored.
- Outputs: if_pc_o=pc. rom_inst_o=inst_q in HOLD, rom_data in FETCH with ack, INST_NOP otherwise.
- stallreq_if_o = (FETCH and not rom_ack) or DRAIN, or flush_i in any state.

## Timing
- Zero-wait ROM (ack in the request cycle): one instruction per cycle, no stall.
- N-cycle ROM latency: stallreq_if_o is high for N-1 cycles per instruction.
- Redirect: the target address appears on rom_addr in the cycle after the delay-slot instruction is consumed, or the cycle after flush (DRAIN adds the remaining ROM latency).
- Simultaneous flush and branch: flush wins and the branch is dropped.
- Reset mid-fetch: state drops immediately. The ROM must tolerate an abandoned request.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - If the next PC has nonzero bits [1:0], no ROM request is issued.
  - The block presents INST_NOP with if_adel_o=1 for that PC in HOLD semantics until consumed.
  - The subsequent flush_i redirects it.
- Undefined: if_adel_o is tied 0 and rom_addr[1:0] is forced to 2'b00.

## Structure
- In project_types: fetch_state_t, INST_NOP (32'h0), PC_STEP (4). reset_status_t, RST_ENABLE, inst_addr_t and inst_t already exist there.
- Single module. Next-PC selection is small enough that no sub-module is warranted.

## Test plan
- Reset release with zero-wait ROM: rom_addr 0,4,8,… on consecutive cycles; stallreq_if_o stays 0.
- ROM ack delayed 2 cycles: stallreq_if_o is high for 2 cycles per fetch; if_pc_o is held stable.
- branch_flag_i=1 with target 0x100 while fetching 0x14: 0x14 is delivered, then rom_addr=0x100.
- flush_i with new_pc_i=0x180 during an unacked fetch of 0x40: DRAIN, 0x40 data discarded, next rom_addr=0x180.
- stall[0]=1 for 3 cycles on ack: HOLD presents the same word and rom_req=0; pc+4 is requested after release.
- IF_ALIGN_CHECK_EN with branch target 0x102: no request issued; if_adel_o=1 and rom_inst_o=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package if_fetch_pkg;

  typedef logic        reset_status_t;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam reset_status_t RST_ENABLE = 1'b0;
  localparam inst_t         INST_NOP   = 32'h0000_0000;
  localparam inst_addr_t    PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Next fetch address: a branch resolved this cycle beats one already pending,
  // which beats sequential flow. The addition wraps at 2^32.
  function automatic inst_addr_t pc_next(input logic       br_now,
                                         input inst_addr_t br_tgt,
                                         input logic       pend,
                                         input inst_addr_t pend_tgt,
                                         input inst_addr_t pc);
    if (br_now)    return br_tgt;
    else if (pend) return pend_tgt;
    else           return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction-ROM request/acknowledge bus
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       rom_req;
  inst_addr_t rom_addr;
  logic       rom_ack;
  inst_t      rom_data;

  modport master (output rom_req, output rom_addr, input rom_ack, input rom_data);
  modport slave  (input rom_req, input rom_addr, output rom_ack, output rom_data);
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - IF stage: PC, ROM handshake, delay-slot branches, flush redirects (optional IF_ALIGN_CHECK_EN)
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic [5:0]    stall,
  input  logic          branch_flag_i,
  input  inst_addr_t    branch_target_i,
  input  logic          flush_i,
  input  inst_addr_t    new_pc_i,
  if_fetch_if.master    rom,
  output inst_addr_t    if_pc_o,
  output inst_t         rom_inst_o,
  output logic          stallreq_if_o,
  output logic          if_adel_o
);

  fetch_state_t state_q;
  inst_addr_t   pc_q;
  inst_t        inst_q;
  logic         redir_pend_q;
  inst_addr_t   redir_tgt_q;
  inst_addr_t   dtgt_q;

  logic         misalign;
  logic         fetch_done;
  logic         consume;
  inst_addr_t   next_pc;
  inst_t        fetch_inst;

  // Only stall[0] belongs to this stage; the other bits steer later stages.
  logic         unused_stall;
  assign unused_stall = ^stall[5:1];

`ifdef IF_ALIGN_CHECK_EN
  // A misaligned PC never reaches the ROM; it is presented as a NOP tagged
  // with the address error until the resulting exception flush redirects it.
  assign misalign = (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign fetch_done = (state_q == FETCH) && (rom.rom_ack || misalign);
  assign consume    = (fetch_done || (state_q == HOLD)) && !stall[0];
  assign fetch_inst = misalign ? INST_NOP : rom.rom_data;
  assign next_pc    = pc_next(branch_flag_i, branch_target_i,
                              redir_pend_q, redir_tgt_q, pc_q);

  // Fetch sequencing: flush has priority, then the per-state handshake, then
  // branch capture for a delay slot that is not consumed this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= INST_NOP;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      dtgt_q       <= '0;
    end else if (flush_i) begin
      redir_pend_q <= 1'b0;
      if ((state_q != HOLD) && !rom.rom_ack && !misalign) begin
        // An outstanding request cannot be withdrawn; let it finish first.
        state_q <= DRAIN;
        dtgt_q  <= new_pc_i;
      end else begin
        state_q <= FETCH;
        pc_q    <= new_pc_i;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_done && stall[0]) begin
            inst_q  <= fetch_inst;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!stall[0]) state_q <= FETCH;
        end
        DRAIN: begin
          if (rom.rom_ack) begin
            pc_q    <= dtgt_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase

      if (consume) begin
        pc_q         <= next_pc;
        redir_pend_q <= 1'b0;
      end else if (branch_flag_i && (state_q != DRAIN)) begin
        redir_pend_q <= 1'b1;
        redir_tgt_q  <= branch_target_i;
      end
    end
  end

  // Bus and pipeline outputs decoded from the current state.
  always_comb begin
    rom.rom_req   = ((state_q == FETCH) && !misalign) || (state_q == DRAIN);
`ifdef IF_ALIGN_CHECK_EN
    rom.rom_addr  = pc_q;
    if_adel_o     = misalign;
`else
    rom.rom_addr  = {pc_q[31:2], 2'b00};
    if_adel_o     = 1'b0;
`endif
    if_pc_o       = pc_q;
    rom_inst_o    = INST_NOP;
    if (state_q == HOLD)
      rom_inst_o = inst_q;
    else if (state_q == FETCH && rom.rom_ack && !misalign)
      rom_inst_o = rom.rom_data;
    stallreq_if_o = ((state_q == FETCH) && !rom.rom_ack && !misalign)
                    || (state_q == DRAIN) || flush_i;
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic          clk;
  reset_status_t rst;
  logic [5:0]    stall;
  logic          branch_flag_i;
  inst_addr_t    branch_target_i;
  logic          flush_i;
  inst_addr_t    new_pc_i;
  inst_addr_t    if_pc_o;
  inst_t         rom_inst_o;
  logic          stallreq_if_o;
  logic          if_adel_o;

  int checks;
  int errors;
  int lat;
  int cnt;

  if_fetch_if rom_bus ();

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .rom             (rom_bus.master),
    .if_pc_o         (if_pc_o),
    .rom_inst_o      (rom_inst_o),
    .stallreq_if_o   (stallreq_if_o),
    .if_adel_o       (if_adel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: acks after `lat` waiting cycles; word = {16'hC0DE, addr[15:0]}.
  assign rom_bus.rom_ack  = rom_bus.rom_req && (cnt >= lat);
  assign rom_bus.rom_data = rom_bus.rom_ack ? {16'hC0DE, rom_bus.rom_addr[15:0]} : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else if (rom_bus.rom_req && !rom_bus.rom_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic test_reset();
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", if_pc_o, 32'h0); end
    checks++; if (rom_bus.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", rom_bus.rom_addr, 32'h0); end
    checks++; if (if_adel_o !== 1'b0) begin errors++; $display("FAIL reset_adel got %b exp 0", if_adel_o); end
  endtask

  task automatic test_zero_wait();
    rst = 1'b1;
    #1;
    checks++; if (rom_bus.rom_addr !== 32'h0) begin errors++; $display("FAIL zw_addr0 got %h exp %h", rom_bus.rom_addr, 32'h0); end
    checks++; if (rom_inst_o !== 32'hC0DE_0000) begin errors++; $display("FAIL zw_inst0 got %h exp %h", rom_inst_o, 32'hC0DE_0000); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (rom_bus.rom_addr !== 32'(4 * i)) begin errors++; $display("FAIL zw_addr got %h exp %h", rom_bus.rom_addr, 32'(4 * i)); end
      checks++; if (if_pc_o !== 32'(4 * i)) begin errors++; $display("FAIL zw_pc got %h exp %h", if_pc_o, 32'(4 * i)); end
      checks++; if (rom_inst_o !== (32'hC0DE_0000 | 32'(4 * i))) begin errors++; $display("FAIL zw_inst got %h exp %h", rom_inst_o, 32'hC0DE_0000 | 32'(4 * i)); end
      checks++; if (stallreq_if_o !== 1'b0) begin errors++; $display("FAIL zw_stall got %b exp 0", stallreq_if_o); end
    end
  endtask

  task automatic test_latency();
    lat = 2;
    #1;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 2; w++) begin
        checks++; if (stallreq_if_o !== 1'b1) begin errors++; $display("FAIL lat_stall got %b exp 1", stallreq_if_o); end
        checks++; if (if_pc_o !== 32'(12 + 4 * f)) begin errors++; $display("FAIL lat_pc got %h exp %h", if_pc_o, 32'(12 + 4 * f)); end
        @(negedge clk);
      end
      checks++; if (stallreq_if_o !== 1'b0) begin errors++; $display("FAIL lat_ack_stall got %b exp 0", stallreq_if_o); end
      checks++; if (rom_inst_o !== (32'hC0DE_0000 | 32'(12 + 4 * f))) begin errors++; $display("FAIL lat_inst got %h exp %h", rom_inst_o, 32'hC0DE_0000 | 32'(12 + 4 * f)); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    checks++; if (rom_bus.rom_addr !== 32'h14) begin errors++; $display("FAIL br_addr_ds got %h exp %h", rom_bus.rom_addr, 32'h14); end
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    @(negedge clk);
    branch_flag_i = 1'b0;
    checks++; if (rom_bus.rom_addr !== 32'h14) begin errors++; $display("FAIL br_addr_hold got %h exp %h", rom_bus.rom_addr, 32'h14); end
    @(negedge clk);
    checks++; if (rom_inst_o !== 32'hC0DE_0014) begin errors++; $display("FAIL br_delay_slot got %h exp %h", rom_inst_o, 32'hC0DE_0014); end
    @(negedge clk);
    checks++; if (rom_bus.rom_addr !== 32'h100) begin errors++; $display("FAIL br_target got %h exp %h", rom_bus.rom_addr, 32'h100); end
    checks++; if (stallreq_if_o !== 1'b1) begin errors++; $display("FAIL br_tgt_stall got %b exp 1", stallreq_if_o); end
  endtask

  task automatic test_flush();
    flush_i = 1'b1; new_pc_i = 32'h40;
    #1;
    checks++; if (stallreq_if_o !== 1'b1) begin errors++; $display("FAIL fl_stall got %b exp 1", stallreq_if_o); end
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (rom_bus.rom_addr !== 32'h100) begin errors++; $display("FAIL fl_drain_addr got %h exp %h", rom_bus.rom_addr, 32'h100); end
    checks++; if (rom_bus.rom_req !== 1'b1) begin errors++; $display("FAIL fl_drain_req got %b exp 1", rom_bus.rom_req); end
    @(negedge clk);
    checks++; if (rom_inst_o !== INST_NOP) begin errors++; $display("FAIL fl_discard got %h exp %h", rom_inst_o, INST_NOP); end
    checks++; if (stallreq_if_o !== 1'b1) begin errors++; $display("FAIL fl_drain_stall got %b exp 1", stallreq_if_o); end
    @(negedge clk);
    checks++; if (rom_bus.rom_addr !== 32'h40) begin errors++; $display("FAIL fl_addr40 got %h exp %h", rom_bus.rom_addr, 32'h40); end
    flush_i = 1'b1; new_pc_i = 32'h180;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (rom_bus.rom_addr !== 32'h40) begin errors++; $display("FAIL fl2_drain_addr got %h exp %h", rom_bus.rom_addr, 32'h40); end
    @(negedge clk);
    checks++; if (rom_inst_o !== INST_NOP) begin errors++; $display("FAIL fl2_discard got %h exp %h", rom_inst_o, INST_NOP); end
    @(negedge clk);
    checks++; if (rom_bus.rom_addr !== 32'h180) begin errors++; $display("FAIL fl2_addr180 got %h exp %h", rom_bus.rom_addr, 32'h180); end
  endtask

  task automatic test_hold();
    lat = 0; stall = 6'b000001;
    #1;
    checks++; if (rom_inst_o !== 32'hC0DE_0180) begin errors++; $display("FAIL hold_ack_inst got %h exp %h", rom_inst_o, 32'hC0DE_0180); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (rom_bus.rom_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b exp 0", rom_bus.rom_req); end
      checks++; if (rom_inst_o !== 32'hC0DE_0180) begin errors++; $display("FAIL hold_inst got %h exp %h", rom_inst_o, 32'hC0DE_0180); end
      checks++; if (if_pc_o !== 32'h180) begin errors++; $display("FAIL hold_pc got %h exp %h", if_pc_o, 32'h180); end
    end
    stall = 6'b000000;
    @(negedge clk);
    checks++; if (rom_bus.rom_addr !== 32'h184) begin errors++; $display("FAIL hold_release_addr got %h exp %h", rom_bus.rom_addr, 32'h184); end
    checks++; if (rom_bus.rom_req !== 1'b1) begin errors++; $display("FAIL hold_release_req got %b exp 1", rom_bus.rom_req); end
  endtask

  task automatic test_flush_branch();
    flush_i = 1'b1; new_pc_i = 32'h200;
    branch_flag_i = 1'b1; branch_target_i = 32'h300;
    @(negedge clk);
    flush_i = 1'b0; branch_flag_i = 1'b0;
    checks++; if (rom_bus.rom_addr !== 32'h200) begin errors++; $display("FAIL fb_flush_wins got %h exp %h", rom_bus.rom_addr, 32'h200); end
    @(negedge clk);
    checks++; if (rom_bus.rom_addr !== 32'h204) begin errors++; $display("FAIL fb_branch_dropped got %h exp %h", rom_bus.rom_addr, 32'h204); end
  endtask

  task automatic test_reset_mid();
    lat = 2;
    #1;
    checks++; if (stallreq_if_o !== 1'b1) begin errors++; $display("FAIL rm_pending got %b exp 1", stallreq_if_o); end
    rst = 1'b0;
    #1;
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rm_pc got %h exp %h", if_pc_o, 32'h0); end
    @(negedge clk);
    rst = 1'b1; lat = 0;
    @(negedge clk);
    checks++; if (rom_bus.rom_addr !== 32'h4) begin errors++; $display("FAIL rm_restart got %h exp %h", rom_bus.rom_addr, 32'h4); end
  endtask

`ifdef IF_ALIGN_CHECK_EN
  task automatic test_align();
    branch_flag_i = 1'b1; branch_target_i = 32'h102;
    @(negedge clk);
    branch_flag_i = 1'b0;
    checks++; if (rom_bus.rom_req !== 1'b0) begin errors++; $display("FAIL al_req got %b exp 0", rom_bus.rom_req); end
    checks++; if (if_adel_o !== 1'b1) begin errors++; $display("FAIL al_adel got %b exp 1", if_adel_o); end
    checks++; if (rom_inst_o !== INST_NOP) begin errors++; $display("FAIL al_inst got %h exp %h", rom_inst_o, INST_NOP); end
    checks++; if (if_pc_o !== 32'h102) begin errors++; $display("FAIL al_pc got %h exp %h", if_pc_o, 32'h102); end
    stall = 6'b000001;
    @(negedge clk);
    checks++; if (if_adel_o !== 1'b1) begin errors++; $display("FAIL al_hold_adel got %b exp 1", if_adel_o); end
    flush_i = 1'b1; new_pc_i = 32'h10;
    @(negedge clk);
    flush_i = 1'b0; stall = 6'b000000;
    checks++; if (rom_bus.rom_addr !== 32'h10) begin errors++; $display("FAIL al_flush_addr got %h exp %h", rom_bus.rom_addr, 32'h10); end
    checks++; if (if_adel_o !== 1'b0) begin errors++; $display("FAIL al_flush_adel got %b exp 0", if_adel_o); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; lat = 0;
    rst = 1'b0; stall = 6'b0;
    branch_flag_i = 1'b0; branch_target_i = '0;
    flush_i = 1'b0; new_pc_i = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_zero_wait();
    test_latency();
    test_branch();
    test_flush();
    test_hold();
    test_flush_branch();
    test_reset_mid();
`ifdef IF_ALIGN_CHECK_EN
    test_align();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
